// File: rtl/rotshift_pkg.sv
// Shared types for the rotate/shift register: step modes and run-control states.
package rotshift_pkg;

    typedef enum logic [1:0] {
        ROT_R = 2'b00,
        ROT_L = 2'b01,
        SHF_R = 2'b10,
        SHF_L = 2'b11
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_rotate(input mode_t m);
        return !m[1];
    endfunction

endpackage

// File: rtl/rotshift_step.sv
// Combinational one-step next value of the register for a given mode and serial input.
module rotshift_step
    import rotshift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_t            mode,
    input  logic             sin,
    output logic [WIDTH-1:0] next_q
);

    always_comb begin
        case (mode)
            ROT_R:   next_q = {q[0], q[WIDTH-1:1]};
            ROT_L:   next_q = {q[WIDTH-2:0], q[WIDTH-1]};
            SHF_R:   next_q = {sin, q[WIDTH-1:1]};
            default: next_q = {q[WIDTH-2:0], sin};
        endcase
    end

endmodule

// File: rtl/param_rotate_shifter.sv
// Rotate/shift register with single steps and counted multi-step runs.
// Define ROTATE_POS_TRACK_EN to track the net rotation offset on pos and pulse wrap.
module param_rotate_shifter
    import rotshift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic             sin,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] pos,
    output logic             wrap
);

    state_t           state_reg, state_next;
    mode_t            run_mode_reg;
    logic [AMT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] q_reg;
    logic             done_reg, done_next;
    logic             take_step, latch_run;
    logic [AMT_W-1:0] amt_sat;
    mode_t            step_mode;
    logic [WIDTH-1:0] step_q;

    assign busy      = (state_reg == RUN);
    assign step_mode = busy ? run_mode_reg : mode_t'(mode);
    assign amt_sat   = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;
    assign q         = q_reg;
    assign done      = done_reg;
    // Right modes expose the LSB, left modes the MSB.
    assign sout      = step_mode[0] ? q_reg[WIDTH-1] : q_reg[0];

    rotshift_step #(.WIDTH(WIDTH)) u_step (
        .q      (q_reg),
        .mode   (step_mode),
        .sin    (sin),
        .next_q (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        take_step  = 1'b0;
        latch_run  = 1'b0;
        if (load) begin
            state_next = IDLE;
        end else if (state_reg == RUN) begin
            take_step = 1'b1;
            if (cnt_reg == AMT_W'(1)) begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
        end else if (start) begin
            // A zero-length run completes immediately without entering RUN.
            if (amt_sat == '0) begin
                done_next = 1'b1;
            end else begin
                state_next = RUN;
                latch_run  = 1'b1;
            end
        end else if (en) begin
            take_step = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg        <= '0;
            done_reg     <= 1'b0;
            cnt_reg      <= '0;
            run_mode_reg <= ROT_R;
        end else begin
            done_reg <= done_next;
            if (load)           q_reg <= data;
            else if (take_step) q_reg <= step_q;
            if (latch_run) begin
                cnt_reg      <= amt_sat;
                run_mode_reg <= mode_t'(mode);
            end else if (take_step && busy) begin
                cnt_reg <= cnt_reg - AMT_W'(1);
            end
        end
    end

`ifdef ROTATE_POS_TRACK_EN
    logic [AMT_W-1:0] pos_reg, pos_next;
    logic             wrap_reg;

    always_comb begin
        pos_next = pos_reg;
        if (load) begin
            pos_next = '0;
        end else if (take_step) begin
            case (step_mode)
                ROT_R:   pos_next = (pos_reg == AMT_W'(WIDTH - 1)) ? '0 : pos_reg + AMT_W'(1);
                ROT_L:   pos_next = (pos_reg == '0) ? AMT_W'(WIDTH - 1) : pos_reg - AMT_W'(1);
                default: pos_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_reg  <= '0;
            wrap_reg <= 1'b0;
        end else begin
            pos_reg  <= pos_next;
            wrap_reg <= !load && take_step && is_rotate(step_mode)
                        && (pos_reg != '0) && (pos_next == '0);
        end
    end

    assign pos  = pos_reg;
    assign wrap = wrap_reg;
`else
    assign pos  = '0;
    assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_param_rotate_shifter.sv
// Randomized self-checking bench for param_rotate_shifter against an arithmetic reference model.
module tb_param_rotate_shifter;

    localparam int W  = 8;
    localparam int AW = $clog2(W) + 1;
`ifdef ROTATE_POS_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, load, en, sin, start;
    logic [W-1:0]  data;
    logic [1:0]    mode;
    logic [AW-1:0] amt;
    logic [W-1:0]  q;
    logic          sout, busy, done, wrap;
    logic [AW-1:0] pos;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] m_q;
    int           m_pos;
    bit           m_wrap;

    always #5 clk = ~clk;

    param_rotate_shifter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data), .mode(mode),
        .en(en), .sin(sin), .start(start), .amt(amt),
        .q(q), .sout(sout), .busy(busy), .done(done), .pos(pos), .wrap(wrap)
    );

    // Reference: rotation/shift as integer arithmetic, offset as a plain modular counter.
    task automatic model_step(input int md, input logic s);
        longint x;
        int old;
        x   = longint'(m_q);
        old = m_pos;
        case (md)
            0: m_q = W'((x >> 1) + (x % 2) * (64'd1 << (W - 1)));
            1: m_q = W'(((x * 2) % (64'd1 << W)) + x / (64'd1 << (W - 1)));
            2: m_q = W'((x >> 1) + longint'(s) * (64'd1 << (W - 1)));
            default: m_q = W'(((x * 2) % (64'd1 << W)) + longint'(s));
        endcase
        if (md == 0)      m_pos = (m_pos + 1) % W;
        else if (md == 1) m_pos = (m_pos + W - 1) % W;
        else              m_pos = 0;
        m_wrap = (md < 2) && (old != 0) && (m_pos == 0);
    endtask

    function automatic int exp_pos();
        return TRACK ? m_pos : 0;
    endfunction

    function automatic bit exp_wrap();
        return TRACK ? m_wrap : 1'b0;
    endfunction

    function automatic logic exp_sout(input int md);
        return (md % 2 == 1) ? m_q[W-1] : m_q[0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1; data = v;
        tick();
        load = 1'b0;
        m_q = v; m_pos = 0; m_wrap = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; load = 0; en = 0; sin = 0; start = 0; data = '0; mode = 2'b00; amt = '0;
        #1 rst_n = 1'b0;
        #1;
        tests++; if (q !== '0)    begin fails++; $display("FAIL reset_q: got %h exp 00", q); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b exp 0", done); end
        tests++; if (pos !== '0 || wrap !== 1'b0) begin fails++; $display("FAIL reset_pos: got %0d/%b exp 0/0", pos, wrap); end
        tick();
        rst_n = 1'b1;
        m_q = '0; m_pos = 0; m_wrap = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_rotate_wrap();
        do_load(8'h80);
        tests++; if (q !== 8'h80) begin fails++; $display("FAIL rot_load: got %h exp 80", q); end
        mode = 2'b00; en = 1'b1;
        for (int i = 0; i < W; i++) begin
            model_step(0, 1'b0);
            tick();
            tests++; if (q !== m_q) begin fails++; $display("FAIL rot_q: got %h exp %h", q, m_q); end
            tests++; if (pos !== AW'(exp_pos())) begin fails++; $display("FAIL rot_pos: got %0d exp %0d", pos, exp_pos()); end
            tests++; if (wrap !== exp_wrap()) begin fails++; $display("FAIL rot_wrap: got %b exp %b", wrap, exp_wrap()); end
        end
        en = 1'b0;
        tick();
        tests++; if (wrap !== 1'b0 || q !== 8'h80) begin fails++; $display("FAIL rot_hold: got %h/%b exp 80/0", q, wrap); end
        $display("[TB] rotate right 8 steps q=%h pos=%0d", q, pos);
    endtask

    task automatic test_random_steps();
        int md;
        bit do_ld, do_en;
        logic [W-1:0] v;
        for (int i = 0; i < 60; i++) begin
            md    = int'($urandom_range(0, 3));
            do_ld = ($urandom_range(0, 7) == 0);
            do_en = ($urandom_range(0, 3) != 0);
            v     = W'($urandom);
            mode = 2'(md); sin = 1'($urandom); en = do_en; load = do_ld; data = v;
            #1;
            tests++; if (sout !== exp_sout(md)) begin fails++; $display("FAIL rnd_sout: got %b exp %b", sout, exp_sout(md)); end
            if (do_ld) begin
                m_q = v; m_pos = 0; m_wrap = 1'b0;
            end else if (do_en) begin
                model_step(md, sin);
            end else begin
                m_wrap = 1'b0;
            end
            tick();
            tests++; if (q !== m_q) begin fails++; $display("FAIL rnd_q: got %h exp %h", q, m_q); end
            tests++; if (pos !== AW'(exp_pos()) || wrap !== exp_wrap()) begin
                fails++; $display("FAIL rnd_pos: got %0d/%b exp %0d/%b", pos, wrap, exp_pos(), exp_wrap());
            end
            tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rnd_ctl: got %b/%b exp 0/0", busy, done); end
        end
        load = 0; en = 0;
        $display("[TB] 60 random single steps q=%h", q);
    endtask

    task automatic run_case(input logic [W-1:0] init, input int md, input int amt_val);
        int n;
        logic [W-1:0] q_start;
        n = (amt_val > W) ? W : amt_val;
        do_load(init);
        q_start = m_q;
        start = 1'b1; mode = 2'(md); amt = AW'(amt_val);
        tick();
        start = 1'b0;
        m_wrap = 1'b0;
        tests++; if (q !== q_start) begin fails++; $display("FAIL run_start_q: got %h exp %h", q, q_start); end
        tests++; if (busy !== (n > 0) || done !== (n == 0)) begin
            fails++; $display("FAIL run_start_ctl: got %b/%b exp %b/%b", busy, done, n > 0, n == 0);
        end
        for (int i = 1; i <= n; i++) begin
            // Start, en and mode changes while busy must not disturb the run.
            mode = 2'($urandom); en = 1'($urandom); start = 1'($urandom); sin = 1'($urandom);
            amt = AW'($urandom);
            #1;
            tests++; if (sout !== exp_sout(md)) begin fails++; $display("FAIL run_sout: got %b exp %b", sout, exp_sout(md)); end
            model_step(md, sin);
            tick();
            tests++; if (q !== m_q) begin fails++; $display("FAIL run_q: got %h exp %h", q, m_q); end
            tests++; if (busy !== (i < n) || done !== (i == n)) begin
                fails++; $display("FAIL run_ctl: step %0d got %b/%b exp %b/%b", i, busy, done, i < n, i == n);
            end
            tests++; if (pos !== AW'(exp_pos()) || wrap !== exp_wrap()) begin
                fails++; $display("FAIL run_pos: got %0d/%b exp %0d/%b", pos, wrap, exp_pos(), exp_wrap());
            end
        end
        en = 1'b0; start = 1'b0;
        tick();
        tests++; if (done !== 1'b0 || busy !== 1'b0 || q !== m_q) begin
            fails++; $display("FAIL run_end: got done=%b busy=%b q=%h exp 0/0/%h", done, busy, q, m_q);
        end
        $display("[TB] run mode=%0d amt=%0d from %h -> q=%h pos=%0d", md, amt_val, init, q, pos);
    endtask

    task automatic test_runs();
        run_case(8'h81, 1, 3);
        tests++; if (q !== 8'h0C) begin fails++; $display("FAIL run_example_q: got %h exp 0c", q); end
        run_case(8'h5A, 0, 0);
        tests++; if (q !== 8'h5A) begin fails++; $display("FAIL run_zero_q: got %h exp 5a", q); end
        run_case(W'($urandom), 0, W + 3);
        for (int k = 0; k < 5; k++) run_case(W'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, W)));
    endtask

    task automatic test_abort();
        do_load(W'($urandom));
        start = 1'b1; mode = 2'b00; amt = AW'(5);
        tick();
        start = 1'b0;
        tick();
        load = 1'b1; data = 8'hA5;
        tick();
        load = 1'b0;
        tests++; if (q !== 8'hA5) begin fails++; $display("FAIL abort_q: got %h exp a5", q); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_ctl: got %b/%b exp 0/0", busy, done); end
        tests++; if (pos !== '0 || wrap !== 1'b0) begin fails++; $display("FAIL abort_pos: got %0d/%b exp 0/0", pos, wrap); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (done !== 1'b0 || q !== 8'hA5) begin fails++; $display("FAIL abort_after: got %b/%h exp 0/a5", done, q); end
        end
        m_q = 8'hA5; m_pos = 0;
        $display("[TB] abort by load q=%h", q);
    endtask

    task automatic test_shift_fill();
        do_load(8'h00);
        mode = 2'b10; sin = 1'b1; en = 1'b1;
        for (int i = 0; i < W; i++) begin
            model_step(2, 1'b1);
            tick();
            tests++; if (q !== m_q) begin fails++; $display("FAIL fill_q: got %h exp %h", q, m_q); end
            tests++; if (pos !== '0 || wrap !== 1'b0) begin fails++; $display("FAIL fill_pos: got %0d/%b exp 0/0", pos, wrap); end
        end
        en = 1'b0;
        tests++; if (q !== 8'hFF) begin fails++; $display("FAIL fill_final: got %h exp ff", q); end
        $display("[TB] shift-right fill q=%h", q);
    endtask

    task automatic test_async_reset();
        do_load(8'h3C);
        start = 1'b1; mode = 2'b01; amt = AW'(6);
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        tests++; if (q !== '0) begin fails++; $display("FAIL areset_q: got %h exp 00", q); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL areset_ctl: got %b/%b exp 0/0", busy, done); end
        tests++; if (pos !== '0 || wrap !== 1'b0) begin fails++; $display("FAIL areset_pos: got %0d/%b exp 0/0", pos, wrap); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++; if (done !== 1'b0 || busy !== 1'b0 || q !== '0) begin
                fails++; $display("FAIL areset_after: got %b/%b/%h exp 0/0/00", done, busy, q);
            end
        end
        $display("[TB] async reset mid-run");
    endtask

    initial begin
        test_reset();
        test_rotate_wrap();
        test_random_steps();
        test_runs();
        test_abort();
        test_shift_fill();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_rotate_shifter.md
PARAM_ROTATE_SHIFTER -- requirements
Module: param_rotate_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits (legal range 2..64).
REQ-002 The block SHALL have derived localparam AMT_W = $clog2(WIDTH)+1, meaning the width of the step-count and position fields.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port load, input, 1, parallel load strobe.
REQ-007 Port data, input, WIDTH, parallel load value.
REQ-008 Port mode, input, 2, step mode: 00 rotate right, 01 rotate left, 10 shift right with sin, 11 shift left with sin.
REQ-009 Port en, input, 1, single-step enable while idle.
REQ-010 Port sin, input, 1, serial input for shift modes.
REQ-011 Port start, input, 1, begins a multi-step run.
REQ-012 Port amt, input, AMT_W, number of steps for a run (0..WIDTH).
REQ-013 Port q, output, WIDTH, register contents.
REQ-014 Port sout, output, 1, the bit that the next step shifts out: q[0] for right modes, q[WIDTH-1] for left modes; selected by the latched run mode when busy, otherwise by mode.
REQ-015 Port busy, output, 1, run in progress.
REQ-016 Port done, output, 1, single-cycle run-completion pulse.
REQ-017 Port pos, output, AMT_W, net rotation offset modulo WIDTH.
REQ-018 Port wrap, output, 1, single-cycle pulse when pos returns to 0.

Function
REQ-019 Right rotate SHALL give q <= {q[0], q[WIDTH-1:1]}; left rotate SHALL give q <= {q[WIDTH-2:0], q[WIDTH-1]}; right shift SHALL give q <= {sin, q[WIDTH-1:1]}; left shift SHALL give q <= {q[WIDTH-2:0], sin}.
REQ-020 Priority per edge SHALL be: load > active run step > start > en > hold.
REQ-021 The block SHALL implement two states: IDLE and RUN.
REQ-022 In IDLE, start with amt > 0 SHALL latch mode and amt, enter RUN and assert busy from the next cycle; no step is taken on the start edge.
REQ-023 In RUN, the block SHALL take exactly one step per cycle, for amt cycles, using the latched mode.
REQ-024 On the edge of the final step, the block SHALL return to IDLE, deassert busy and assert done for one cycle.
REQ-025 Start with amt = 0 SHALL produce only a done pulse in the next cycle: no step, busy stays 0.
REQ-026 Start with amt > WIDTH SHALL be saturated to WIDTH.
REQ-027 Start and en SHALL be ignored while busy.
REQ-028 Load in RUN SHALL abort the run: q <= data, the block returns to IDLE, and no done pulse is produced.
REQ-029 In IDLE, en with start low SHALL take one step in the current mode.
REQ-030 Load in IDLE SHALL set q <= data.

Reset
REQ-031 When rst_n is low, the block SHALL asynchronously set q=0, state=IDLE, busy=0, done=0, pos=0 and wrap=0.
REQ-032 Reset asserted mid-run SHALL discard the run with no done pulse.

Configuration
REQ-033 When macro ROTATE_POS_TRACK_EN is defined, pos SHALL increment by 1 modulo WIDTH on each right-rotate step and decrement by 1 modulo WIDTH on each left-rotate step.
REQ-034 With ROTATE_POS_TRACK_EN defined, pos SHALL clear to 0 on load or on any shift-mode step.
REQ-035 With ROTATE_POS_TRACK_EN defined, wrap SHALL pulse for one cycle after a rotate step that brings pos from nonzero to 0.
REQ-036 When ROTATE_POS_TRACK_EN is undefined, pos and wrap SHALL be tied to 0 and no tracking logic shall be generated.

Structure
REQ-037 Package rotshift_pkg SHALL hold the mode enum (ROT_R, ROT_L, SHF_R, SHF_L) and the state enum (IDLE, RUN).
REQ-038 Sub-module rotshift_step (combinational next-q from q, mode and sin) SHALL be instantiated once.

Verification
REQ-039 WIDTH=4: load 4'b1000, mode=00, en=1 for 4 cycles -> q = 0100, 0010, 0001, 1000; wrap pulses on the 4th step (macro on).
REQ-040 WIDTH=8: load 8'h81, start with mode=01, amt=3 -> busy for 3 cycles, q=8'h0C, done pulses in the cycle after the last step, pos=5.
REQ-041 Start with amt=0 -> done pulses in the next cycle, busy stays 0, q unchanged.
REQ-042 Run with amt=5, load=1 with data=8'hA5 on the 2nd step cycle -> q=8'hA5, busy=0 in the next cycle, no done pulse.
REQ-043 mode=10, sin=1, en=1 for 8 cycles from q=0 -> q=8'hFF, pos stays 0, wrap never pulses.
REQ-044 rst_n pulsed low mid-run -> q=0, busy=0, done=0 immediately, asynchronously with no clock edge.
